// File: rtl/l1_access_scheduler.sv
// Lookup-port scheduler for the split L1: arbitrates snoop / data / ifetch requests,
// keeps one lookup in flight with a bounded wait, and walks every set on a cache clear.
module l1_access_scheduler #(
  parameter int ADDR_W  = 32,
  parameter int IDX_W   = 14,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_d_req_valid,
  output logic              o_d_req_ready,
  input  logic              i_d_req_wr,
  input  logic [ADDR_W-1:0] i_d_req_addr,
  input  logic              i_i_req_valid,
  output logic              o_i_req_ready,
  input  logic [ADDR_W-1:0] i_i_req_addr,
  input  logic              i_s_req_valid,
  output logic              o_s_req_ready,
  input  logic              i_s_req_kind,
  input  logic [ADDR_W-1:0] i_s_req_addr,
  input  logic              i_clr_req,
  output logic              o_lk_valid,
  output logic [3:0]        o_lk_cmd,
  output logic [ADDR_W-1:0] o_lk_addr,
  input  logic              i_lk_done,
  output logic              o_clr_valid,
  output logic [IDX_W-1:0]  o_clr_index,
  output logic              o_clr_busy,
  output logic              o_err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CLEAR} state_t;

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  state_t              r_state;
  state_t              w_next;
  logic                r_rr_last;
  logic                r_clr_pending;
  logic [7:0]          r_wait_cnt;
  logic [IDX_W-1:0]    r_clr_idx;
  logic [3:0]          r_lk_cmd;
  logic [ADDR_W-1:0]   r_lk_addr;

  logic                w_arb_en;
  logic                w_s_win;
  logic                w_d_win;
  logic                w_i_win;
  logic                w_accept;
  logic [8:0]          w_wait_inc;
  logic                w_timeout;
  logic                w_clr_last;
  logic [3:0]          w_cmd;
  logic [ADDR_W-1:0]   w_addr;

  // rst_n gates arbitration so no ready leaks out while reset is held
  assign w_arb_en   = rst_n && (r_state == S_IDLE) && !r_clr_pending;
  assign w_s_win    = i_s_req_valid;
  assign w_d_win    = !i_s_req_valid && i_d_req_valid && (!i_i_req_valid || r_rr_last);
  assign w_i_win    = !i_s_req_valid && i_i_req_valid && (!i_d_req_valid || !r_rr_last);

  assign o_s_req_ready = w_arb_en && w_s_win;
  assign o_d_req_ready = w_arb_en && w_d_win;
  assign o_i_req_ready = w_arb_en && w_i_win;
  assign w_accept      = o_s_req_ready || o_d_req_ready || o_i_req_ready;

  // Threshold is checked against the post-increment count, so the abort lands
  // on the TIMEOUT-th WAIT cycle; a done in that same cycle still wins.
  assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;
  assign w_timeout  = (r_state == S_WAIT) && !i_lk_done && (w_wait_inc == TO_LIM);
  assign w_clr_last = &r_clr_idx;

  always_comb begin
    w_cmd  = {3'b000, i_d_req_wr};
    w_addr = i_d_req_addr;
    if (o_s_req_ready) begin
      w_cmd  = i_s_req_kind ? 4'd4 : 4'd3;
      w_addr = i_s_req_addr;
    end else if (o_i_req_ready) begin
      w_cmd  = 4'd2;
      w_addr = i_i_req_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // A fresh clr_req in an otherwise idle cycle starts the walk at once
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_clr_pending)  w_next = S_CLEAR;
        else if (w_accept)  w_next = S_ISSUE;
        else if (i_clr_req) w_next = S_CLEAR;
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (i_lk_done || w_timeout) w_next = S_IDLE;
      S_CLEAR: if (w_clr_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last     <= 1'b1;
      r_clr_pending <= 1'b0;
      r_wait_cnt    <= '0;
      r_clr_idx     <= '0;
      r_lk_cmd      <= '0;
      r_lk_addr     <= '0;
    end else begin
      if (w_accept) begin
        r_lk_cmd  <= w_cmd;
        r_lk_addr <= w_addr;
      end
      if (o_d_req_ready)      r_rr_last <= 1'b0;
      else if (o_i_req_ready) r_rr_last <= 1'b1;
      if (r_state == S_WAIT) r_wait_cnt <= w_wait_inc[7:0];
      else                   r_wait_cnt <= '0;
      if ((r_state == S_CLEAR) && w_clr_last)    r_clr_pending <= 1'b0;
      else if (i_clr_req && (r_state != S_CLEAR)) r_clr_pending <= 1'b1;
      // Index wraps back to 0 after the last set, ready for the next walk
      if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  always_comb begin
    o_lk_valid    = (r_state == S_ISSUE);
    o_clr_valid   = (r_state == S_CLEAR);
    o_clr_busy    = r_clr_pending || (r_state == S_CLEAR);
    o_err_timeout = w_timeout;
    o_lk_cmd      = r_lk_cmd;
    o_lk_addr     = r_lk_addr;
    o_clr_index   = r_clr_idx;
  end

endmodule
